// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - framebuffer RAM arbiter: VGA reads first, CPU stores buffered and drained
module vram_arbiter #(
  parameter logic [31:0] FB_BASE      = 32'h0000_1000,
  parameter int          FB_WORDS     = 4096,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          STARVE_LIMIT = 8,
  localparam int         AW           = $clog2(FB_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_valid,
  output logic          vga_miss,
  output logic [11:0]   vga_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [11:0]   ram_wdata,
  input  logic [11:0]   ram_rdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [32:0] FB_END = {1'b0, FB_BASE} + 33'(FB_WORDS) * 33'd4;

  logic [AW+11:0] fifo_mem [FIFO_DEPTH];
  logic [AW+11:0] head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [SW-1:0]  starve_cnt;
  logic [31:0]    cpu_off;
  logic           win_hit;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           force_wr;
  logic           vga_grant;
  logic           unused_bits;

  assign vga_rdata   = ram_rdata;
  assign head        = fifo_mem[rd_ptr];
  assign unused_bits = ^{cpu_wdata[31:12], cpu_off[31:AW+2], cpu_off[1:0]};

  always_comb begin
    cpu_off    = cpu_addr - FB_BASE;
    win_hit    = cpu_we && ({1'b0, cpu_addr} >= {1'b0, FB_BASE}) && ({1'b0, cpu_addr} < FB_END);
    fifo_empty = (count == '0);
    fifo_full  = (count == CW'(FIFO_DEPTH));
    cpu_stall  = win_hit && fifo_full;
    push       = win_hit && !fifo_full;
    // The count is cleared asynchronously, so only the VGA grant needs explicit reset gating.
    force_wr   = (starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty;
    vga_grant  = reset && vga_req && !force_wr;
    pop        = force_wr || (!vga_req && !fifo_empty);
    ram_en     = vga_grant || pop;
    ram_we     = pop;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (pop) begin
      ram_addr  = head[AW+11:12];
      ram_wdata = head[11:0];
    end else if (vga_grant) begin
      ram_addr = vga_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cpu_off[AW+1:2], cpu_wdata[11:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      vga_valid  <= 1'b0;
      vga_miss   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Counts only cycles where the CPU is blocked because VGA owns the RAM.
      if (cpu_stall && vga_req && !force_wr) begin
        if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      vga_valid <= vga_grant;
      vga_miss  <= vga_req && force_wr;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

  localparam logic [31:0] FB_BASE = 32'h0000_1000;
  localparam logic [31:0] FB_END  = 32'h0000_5000;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        vga_req;
  logic [11:0] vga_addr;
  logic        vga_valid;
  logic        vga_miss;
  logic [11:0] vga_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  int total;
  int bad;

  logic [11:0] vram [4096];

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_miss(vga_miss),
    .vga_rdata(vga_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) vram[ram_addr] <= ram_wdata;
      else        ram_rdata <= vram[ram_addr];
    end
  end

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vga_req = 1'b0; vga_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_we = 1'b1; cpu_addr = FB_BASE + 32'($urandom_range(0, 63));
      cpu_wdata = $urandom; vga_req = 1'b1; vga_addr = 12'($urandom);
      @(negedge clk);
      total++;
      if ({cpu_stall, vga_valid, vga_miss, ram_en, ram_we, ram_addr, ram_wdata} !== 29'd0) begin
        bad++;
        $display("FAIL reset_outputs: got stall=%b valid=%b miss=%b en=%b we=%b addr=%h wdata=%h, want all 0",
                 cpu_stall, vga_valid, vga_miss, ram_en, ram_we, ram_addr, ram_wdata);
      end
      next_cycle();
    end
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ram_en, vga_valid, vga_miss} !== 3'b000) begin
        bad++;
        $display("FAIL reset_release_idle: en=%b valid=%b miss=%b want 000", ram_en, vga_valid, vga_miss);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_store();
    do_reset();
    cpu_we = 1'b1; cpu_addr = FB_BASE + 32'd8; cpu_wdata = 32'd7;
    @(negedge clk);
    total++;
    if ({cpu_stall, ram_en} !== 2'b00) begin
      bad++;
      $display("FAIL store_accept: stall=%b en=%b want 0 0", cpu_stall, ram_en);
    end
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    total++;
    if ({cpu_stall, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b0, 1'b1, 1'b1, 12'd2, 12'd7}) begin
      bad++;
      $display("FAIL store_write: stall=%b en=%b we=%b addr=%0d wdata=%0d want 0 1 1 2 7",
               cpu_stall, ram_en, ram_we, ram_addr, ram_wdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (ram_en !== 1'b0) begin
      bad++;
      $display("FAIL store_once: en=%b want 0", ram_en);
    end
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [2];
    addrs[0] = 32'd96;
    addrs[1] = FB_END;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      cpu_we = 1'b1; cpu_addr = addrs[j]; cpu_wdata = $urandom;
      @(negedge clk);
      next_cycle();
      cpu_we = 1'b0;
      @(negedge clk);
      total++;
      if ({cpu_stall, ram_en} !== 2'b00) begin
        bad++;
        $display("FAIL out_of_window_%0h: stall=%b en=%b want 0 0", addrs[j], cpu_stall, ram_en);
      end
      next_cycle();
    end
    cpu_we = 1'b1; cpu_addr = FB_END - 32'd1; cpu_wdata = 32'h0000_F3C3;
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 12'hFFF, 12'h3C3}) begin
      bad++;
      $display("FAIL last_word: en=%b we=%b addr=%h wdata=%h want 1 1 fff 3c3",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    next_cycle();
  endtask

  task automatic test_vga_read();
    do_reset();
    cpu_we = 1'b1; cpu_addr = FB_BASE + 32'd20; cpu_wdata = 32'h0000_0ABC;
    next_cycle();
    cpu_addr = FB_BASE + 32'd24; cpu_wdata = 32'h0000_0123;
    next_cycle();
    cpu_we = 1'b0;
    next_cycle();
    next_cycle();
    vga_req = 1'b1; vga_addr = 12'd5;
    @(negedge clk);
    total++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 12'd5}) begin
      bad++;
      $display("FAIL vga_grant: en=%b we=%b addr=%0d want 1 0 5", ram_en, ram_we, ram_addr);
    end
    next_cycle();
    vga_addr = 12'd6;
    @(negedge clk);
    total++;
    if ({vga_valid, vga_miss, vga_rdata} !== {1'b1, 1'b0, 12'hABC}) begin
      bad++;
      $display("FAIL vga_data_0: valid=%b miss=%b rdata=%h want 1 0 abc", vga_valid, vga_miss, vga_rdata);
    end
    next_cycle();
    vga_req = 1'b0;
    @(negedge clk);
    total++;
    if ({vga_valid, vga_miss, vga_rdata} !== {1'b1, 1'b0, 12'h123}) begin
      bad++;
      $display("FAIL vga_data_1: valid=%b miss=%b rdata=%h want 1 0 123", vga_valid, vga_miss, vga_rdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({vga_valid, vga_miss} !== 2'b00) begin
      bad++;
      $display("FAIL vga_valid_drop: valid=%b miss=%b want 0 0", vga_valid, vga_miss);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    vga_req = 1'b1; vga_addr = 12'd0;
    for (int k = 0; k < 4; k++) begin
      cpu_we = 1'b1; cpu_addr = FB_BASE + 32'(4 * (20 + k)); cpu_wdata = 32'(100 + k);
      @(negedge clk);
      total++;
      if ({cpu_stall, ram_we} !== 2'b00) begin
        bad++;
        $display("FAIL starve_fill_%0d: stall=%b we=%b want 0 0", k, cpu_stall, ram_we);
      end
      next_cycle();
    end
    cpu_addr = FB_BASE + 32'd96; cpu_wdata = 32'd104;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      total++;
      if ({cpu_stall, ram_en, ram_we, vga_miss} !== 4'b1100) begin
        bad++;
        $display("FAIL starve_wait_%0d: stall=%b en=%b we=%b miss=%b want 1 1 0 0",
                 c, cpu_stall, ram_en, ram_we, vga_miss);
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({cpu_stall, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, 12'd20, 12'd100}) begin
      bad++;
      $display("FAIL force_write: stall=%b en=%b we=%b addr=%0d wdata=%0d want 1 1 1 20 100",
               cpu_stall, ram_en, ram_we, ram_addr, ram_wdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({cpu_stall, vga_miss, vga_valid} !== 3'b010) begin
      bad++;
      $display("FAIL force_after: stall=%b miss=%b valid=%b want 0 1 0", cpu_stall, vga_miss, vga_valid);
    end
    next_cycle();
    cpu_addr = FB_BASE + 32'd100; cpu_wdata = 32'd105;
    @(negedge clk);
    total++;
    if ({cpu_stall, vga_miss, vga_valid} !== 3'b101) begin
      bad++;
      $display("FAIL miss_pulse: stall=%b miss=%b valid=%b want 1 0 1", cpu_stall, vga_miss, vga_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    vga_req = 1'b1; vga_addr = 12'd3;
    for (int k = 0; k < 3; k++) begin
      cpu_we = 1'b1; cpu_addr = FB_BASE + 32'(4 * (40 + k)); cpu_wdata = 32'(12'h111 * (k + 1));
      next_cycle();
    end
    cpu_we = 1'b0;
    @(negedge clk);
    total++;
    if (vga_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: valid=%b want 1", vga_valid);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({vga_valid, vga_miss, ram_en, ram_we} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: valid=%b miss=%b en=%b we=%b want 0000", vga_valid, vga_miss, ram_en, ram_we);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;
    vga_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({ram_we, cpu_stall, vga_valid} !== 3'b000) begin
        bad++;
        $display("FAIL discarded_%0d: we=%b addr=%0d stall=%b valid=%b want no write",
                 i, ram_we, ram_addr, cpu_stall, vga_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int          q_addr [$];
    int          q_data [$];
    logic [11:0] shadow [4096];
    bit          known [4096];
    int          starve;
    bit          exp_valid, exp_miss, rd_known, hit, full, frc, stall_e, pop_e, prev_stall;
    logic [11:0] exp_rdata;
    logic [11:0] e_addr, e_wdata, idx;
    logic        e_en, e_we;
    int          bias;
    longint      a;
    do_reset();
    starve = 0; exp_valid = 0; exp_miss = 0; rd_known = 0; prev_stall = 0; exp_rdata = '0;
    for (int i = 0; i < 4096; i++) known[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) bias = $urandom_range(0, 10);
      if (!prev_stall) begin
        cpu_we = ($urandom_range(0, 1) == 1);
        cpu_wdata = $urandom;
        case ($urandom_range(0, 9))
          0:       cpu_addr = 32'd96;
          1:       cpu_addr = FB_END;
          2:       cpu_addr = FB_BASE - 32'd4;
          3:       cpu_addr = FB_END - 32'd4 + 32'($urandom_range(0, 3));
          default: cpu_addr = FB_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        endcase
      end
      vga_req = ($urandom_range(0, 9) < bias);
      vga_addr = 12'($urandom_range(0, 15));

      a = longint'(cpu_addr);
      hit = cpu_we && a >= 64'h1000 && a < 64'h1000 + 4 * 4096;
      idx = 12'((a - 64'h1000) / 4);
      full = (q_addr.size() == DEPTH);
      stall_e = hit && full;
      frc = (starve == LIMIT) && (q_addr.size() > 0);
      pop_e = frc || (!vga_req && q_addr.size() > 0);
      e_en = pop_e || vga_req;
      e_we = pop_e;
      e_addr = pop_e ? 12'(q_addr[0]) : (vga_req ? vga_addr : 12'd0);
      e_wdata = pop_e ? 12'(q_data[0]) : 12'd0;

      @(negedge clk);
      total++;
      if ({cpu_stall, ram_en, ram_we, ram_addr, ram_wdata} !== {stall_e, e_en, e_we, e_addr, e_wdata}) begin
        bad++;
        $display("FAIL rand_ram cyc=%0d: got stall=%b en=%b we=%b addr=%h wd=%h want %b %b %b %h %h",
                 cyc, cpu_stall, ram_en, ram_we, ram_addr, ram_wdata, stall_e, e_en, e_we, e_addr, e_wdata);
      end
      total++;
      if ({vga_valid, vga_miss} !== {exp_valid, exp_miss}) begin
        bad++;
        $display("FAIL rand_vga cyc=%0d: got valid=%b miss=%b want %b %b",
                 cyc, vga_valid, vga_miss, exp_valid, exp_miss);
      end
      if (exp_valid && rd_known) begin
        total++;
        if (vga_rdata !== exp_rdata) begin
          bad++;
          $display("FAIL rand_rdata cyc=%0d: got %h want %h", cyc, vga_rdata, exp_rdata);
        end
      end
      next_cycle();

      exp_valid = vga_req && !frc;
      exp_miss = vga_req && frc;
      if (exp_valid) begin
        rd_known = known[vga_addr];
        exp_rdata = shadow[vga_addr];
      end
      if (pop_e) begin
        shadow[q_addr[0]] = 12'(q_data[0]);
        known[q_addr[0]] = 1;
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (hit && !full) begin
        q_addr.push_back(int'(idx));
        q_data.push_back(int'(cpu_wdata[11:0]));
      end
      if (stall_e && vga_req && !frc) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
      prev_stall = stall_e;
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    ram_rdata = '0;
    reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single_store();
    test_out_of_window();
    test_vga_read();
    test_starvation();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
